sorted_index_gather: RTL

SORTED_INDEX_GATHER -- requirements
Module: sorted_index_gather

---
 rtl/sorted_index_gather.sv | 119 +++++++++++
 1 files changed

// File: rtl/sorted_index_gather.sv
// Purpose: captures one frame of N_INPUTS words plus a sorted index vector, then streams the words in index order.
// Latency: first beat valid one cycle after the capture edge; one beat per cycle while out_ready is high.
// Backpressure: out_ready low holds every output stable; in_ready is low for the whole time a frame is streaming.
//
// Ports:
//   clk, rst_n          - single clock, asynchronous active-low reset
//   in_valid/in_ready   - frame handshake; data_in (N_INPUTS words) and idx_in (N_INPUTS indices) sampled on capture
//   out_valid/out_ready - beat handshake; out_data/out_index/out_pos/out_last describe the current beat
//   perm_err            - captured index vector was not a permutation of 0..N_INPUTS-1 (held until next capture)
module sorted_index_gather #(
  parameter int DATA_WIDTH  = 32,
  parameter int N_INPUTS    = 8,
  parameter int INDEX_WIDTH = $clog2(N_INPUTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0]  data_in,
  input  logic [N_INPUTS*INDEX_WIDTH-1:0] idx_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [INDEX_WIDTH-1:0]          out_index,
  output logic [INDEX_WIDTH-1:0]          out_pos,
  output logic                            out_last,
  output logic                            perm_err
);

  localparam int                     N_CODES  = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0]   N_EXT    = (INDEX_WIDTH+1)'(N_INPUTS);
  localparam logic [INDEX_WIDTH-1:0] LAST_POS = INDEX_WIDTH'(N_INPUTS-1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] pos;
  logic                   perm_err_q;
  logic [DATA_WIDTH-1:0]  data_buf [N_INPUTS];
  logic [INDEX_WIDTH-1:0] idx_buf  [N_INPUTS];

  // Permutation check on the incoming index vector: flags any out-of-range
  // code and any code already seen in a lower slot.
  logic [N_CODES-1:0]     seen;
  logic [INDEX_WIDTH-1:0] chk_idx;
  logic                   perm_bad;

  always_comb begin
    seen     = '0;
    chk_idx  = '0;
    perm_bad = 1'b0;
    for (int k = 0; k < N_INPUTS; k++) begin
      chk_idx = idx_in[k*INDEX_WIDTH +: INDEX_WIDTH];
      if ({1'b0, chk_idx} >= N_EXT) perm_bad = 1'b1;
      if (seen[chk_idx])            perm_bad = 1'b1;
      seen[chk_idx] = 1'b1;
    end
  end

  // Output word select. Done as a compare-per-slot mux so an index code with
  // no matching slot (only possible when N_INPUTS is not a power of two)
  // falls through to zero instead of reading past the buffer.
  logic [INDEX_WIDTH-1:0] cur_idx;
  logic [DATA_WIDTH-1:0]  sel_data;

  assign cur_idx = idx_buf[pos];

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (cur_idx == INDEX_WIDTH'(k)) sel_data = data_buf[k];
    end
  end

  // Handshake flags come straight from the state register; beat fields are
  // forced to zero outside STREAM so idle/reset outputs are clean.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == STREAM);
  assign out_pos   = out_valid ? pos      : '0;
  assign out_index = out_valid ? cur_idx  : '0;
  assign out_data  = out_valid ? sel_data : '0;
  assign out_last  = out_valid && (pos == LAST_POS);
  assign perm_err  = perm_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos        <= '0;
      perm_err_q <= 1'b0;
      for (int k = 0; k < N_INPUTS; k++) begin
        data_buf[k] <= '0;
        idx_buf[k]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_INPUTS; k++) begin
              data_buf[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
              idx_buf[k]  <= idx_in[k*INDEX_WIDTH +: INDEX_WIDTH];
            end
            perm_err_q <= perm_bad;
            pos        <= '0;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            // pos stops at the last position; leaving STREAM ends the frame.
            if (pos == LAST_POS) state <= IDLE;
            else                 pos   <= pos + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
